// File: rtl/move_merge_tiles_if.sv
// Move request / result bundle of the 2048 move engine.
// master: direction, board_in out; board_out, score_update, done in.
interface move_merge_tiles_if;
  logic [3:0]             direction;
  logic [3:0][3:0][11:0]  board_in;
  logic [3:0][3:0][11:0]  board_out;
  logic [19:0]            score_update;
  logic                   done;

  modport master (
    output direction,
    output board_in,
    input  board_out,
    input  score_update,
    input  done
  );

  modport slave (
    input  direction,
    input  board_in,
    output board_out,
    output score_update,
    output done
  );
endinterface

// File: rtl/move_merge_tiles.sv
// 2048 move engine: slide + merge a latched 4x4 board in one direction.
// Ports: clk, rst_n (async low), bus (slave). `MOVE_MERGE_SCORE_EN adds score.
module move_merge_tiles (
  input logic clk,
  input logic rst_n,
  move_merge_tiles_if.slave bus
);

  typedef logic [3:0][11:0] line_t;
  typedef logic [3:0][3:0][11:0] board_t;

  typedef enum logic [1:0] {
    IDLE,
    MERGE,
    DONE,
    RELEASE
  } state_t;

  state_t     state_q, state_d;
  board_t     board_q, board_d;
  logic [3:0] dir_q, dir_d;
  board_t     out_q, out_d;
  board_t     moved;
  line_t      lines_in [4];
  line_t      lines_out [4];
  logic       req_ok;

  function automatic line_t compress(line_t a);
    line_t c;
    logic [2:0] k;
    c = '0;
    k = '0;
    for (int i = 0; i < 4; i++) begin
      if (a[i] != 12'd0) begin
        c[k[1:0]] = a[i];
        k = k + 3'd1;
      end
    end
    return c;
  endfunction

  // Index 0 is the destination edge. The extra zero slot lets the
  // last tile look ahead without an out-of-range read.
  function automatic line_t slide(line_t a);
    logic [4:0][11:0] c;
    line_t o;
    logic [2:0] k;
    logic skip;
    c = {12'd0, compress(a)};
    o = '0;
    k = '0;
    skip = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (c[i] != 12'd0 && c[i] != 12'd2048
                   && c[i] == c[i+1]) begin
        o[k[1:0]] = c[i] << 1;
        k = k + 3'd1;
        skip = 1'b1;
      end else begin
        o[k[1:0]] = c[i];
        k = k + 3'd1;
      end
    end
    return o;
  endfunction

`ifdef MOVE_MERGE_SCORE_EN
  function automatic logic [19:0] points(line_t a);
    logic [4:0][11:0] c;
    logic [19:0] s;
    logic skip;
    c = {12'd0, compress(a)};
    s = '0;
    skip = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (c[i] != 12'd0 && c[i] != 12'd2048
                   && c[i] == c[i+1]) begin
        s = s + ({8'd0, c[i]} << 1);
        skip = 1'b1;
      end
    end
    return s;
  endfunction

  logic [19:0] score_q, score_d;
  logic [19:0] score_sum;

  always_comb begin
    score_sum = '0;
    for (int l = 0; l < 4; l++) begin
      score_sum = score_sum + points(lines_in[l]);
    end
  end
`endif

  // Gather each line ordered from the destination edge, slide it,
  // and scatter it back with the same mapping.
  always_comb begin
    moved = '0;
    for (int l = 0; l < 4; l++) begin
      lines_in[l] = '0;
      for (int p = 0; p < 4; p++) begin
        unique case (1'b1)
          dir_q[0]: lines_in[l][p] = board_q[p][l];
          dir_q[1]: lines_in[l][p] = board_q[3-p][l];
          dir_q[2]: lines_in[l][p] = board_q[l][p];
          dir_q[3]: lines_in[l][p] = board_q[l][3-p];
          default: lines_in[l][p] = 12'd0;
        endcase
      end
      lines_out[l] = slide(lines_in[l]);
      for (int p = 0; p < 4; p++) begin
        unique case (1'b1)
          dir_q[0]: moved[p][l] = lines_out[l][p];
          dir_q[1]: moved[3-p][l] = lines_out[l][p];
          dir_q[2]: moved[l][p] = lines_out[l][p];
          dir_q[3]: moved[l][3-p] = lines_out[l][p];
          default: ;
        endcase
      end
    end
  end

  assign req_ok = (bus.direction != 4'd0) &&
    ((bus.direction & (bus.direction - 4'd1)) == 4'd0);

  always_comb begin
    state_d = state_q;
    board_d = board_q;
    dir_d   = dir_q;
    out_d   = out_q;
`ifdef MOVE_MERGE_SCORE_EN
    score_d = score_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_ok) begin
          board_d = bus.board_in;
          dir_d   = bus.direction;
          state_d = MERGE;
        end
      end
      MERGE: begin
        out_d   = moved;
`ifdef MOVE_MERGE_SCORE_EN
        score_d = score_sum;
`endif
        state_d = DONE;
      end
      DONE: state_d = RELEASE;
      RELEASE: begin
        if (bus.direction == 4'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      board_q <= '0;
      dir_q   <= '0;
      out_q   <= '0;
`ifdef MOVE_MERGE_SCORE_EN
      score_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
`ifdef MOVE_MERGE_SCORE_EN
      score_q <= score_d;
`endif
    end
  end

  assign bus.board_out = out_q;
  assign bus.done      = (state_q == DONE);
`ifdef MOVE_MERGE_SCORE_EN
  assign bus.score_update = score_q;
`else
  assign bus.score_update = '0;
`endif

endmodule

// File: tb/tb_move_merge_tiles.sv
// Directed bench for move_merge_tiles: vector table plus
// reset, hold and illegal-direction sequences.
module tb_move_merge_tiles;

  typedef logic [3:0][11:0] line_t;
  typedef logic [3:0][3:0][11:0] board_t;

  typedef struct {
    board_t      bin;
    logic [3:0]  dir;
    board_t      bout;
    logic [19:0] score;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   pulses;
  vec_t vecs [6];
  board_t last_out;

  move_merge_tiles_if bus ();

  move_merge_tiles dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic line_t row(int a, int b, int c, int d);
    line_t r;
    r[0] = 12'(a);
    r[1] = 12'(b);
    r[2] = 12'(c);
    r[3] = 12'(d);
    return r;
  endfunction

  task automatic chk_bit(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk_brd(string nm, board_t act, board_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_scr(string nm, logic [19:0] act,
                         logic [19:0] exp);
    logic [19:0] e;
`ifdef MOVE_MERGE_SCORE_EN
    e = exp;
`else
    e = 20'd0;
`endif
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, e);
    end
  endtask

  task automatic do_move(int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    @(negedge clk);
    bus.board_in  = vecs[idx].bin;
    bus.direction = vecs[idx].dir;
    @(posedge clk);
    @(negedge clk);
    bus.board_in = '0;
    chk_bit({nm, "_early_done"}, bus.done, 1'b0);
    @(posedge clk);
    #1;
    chk_bit({nm, "_done"}, bus.done, 1'b1);
    chk_brd({nm, "_board"}, bus.board_out, vecs[idx].bout);
    chk_scr({nm, "_score"}, bus.score_update, vecs[idx].score);
    @(posedge clk);
    #1;
    chk_bit({nm, "_done_low"}, bus.done, 1'b0);
    bus.direction = 4'd0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    board_t b;
    checks = 0;
    errors = 0;

    // down move
    b = '0;
    b[0] = row(2, 2, 4, 4);
    b[1] = row(2, 2, 4, 4);
    b[2] = row(0, 0, 4, 0);
    b[3] = row(8, 0, 4, 0);
    vecs[0].bin = b;
    vecs[0].dir = 4'b0010;
    b = '0;
    b[2] = row(4, 0, 8, 0);
    b[3] = row(8, 4, 8, 8);
    vecs[0].bout = b;
    vecs[0].score = 20'h20;

    // left merge order
    b = '0;
    b[0] = row(2, 2, 2, 2);
    b[1] = row(4, 0, 4, 8);
    vecs[1].bin = b;
    vecs[1].dir = 4'b0100;
    b = '0;
    b[0] = row(4, 4, 0, 0);
    b[1] = row(8, 8, 0, 0);
    vecs[1].bout = b;
    vecs[1].score = 20'd16;

    // right: 2048 cap, plus pairs
    b = '0;
    b[0] = row(2048, 2048, 0, 0);
    b[1] = row(2, 2, 4, 4);
    vecs[2].bin = b;
    vecs[2].dir = 4'b1000;
    b = '0;
    b[0] = row(0, 0, 2048, 2048);
    b[1] = row(0, 0, 4, 8);
    vecs[2].bout = b;
    vecs[2].score = 20'd12;

    // up, no-op full board
    b = '0;
    b[0] = row(2, 4, 2, 4);
    b[1] = row(4, 2, 4, 2);
    b[2] = row(2, 4, 2, 4);
    b[3] = row(4, 2, 4, 2);
    vecs[3].bin = b;
    vecs[3].dir = 4'b0001;
    vecs[3].bout = b;
    vecs[3].score = 20'd0;

    // up with gaps
    b = '0;
    b[1][0] = 12'd2;
    b[3][0] = 12'd2;
    b[0][3] = 12'd8;
    b[1][3] = 12'd8;
    b[2][3] = 12'd8;
    vecs[4].bin = b;
    vecs[4].dir = 4'b0001;
    b = '0;
    b[0][0] = 12'd4;
    b[0][3] = 12'd16;
    b[1][3] = 12'd8;
    vecs[4].bout = b;
    vecs[4].score = 20'd20;

    // new 2048 does not re-merge in the same move
    b = '0;
    b[2] = row(1024, 1024, 2048, 0);
    vecs[5].bin = b;
    vecs[5].dir = 4'b0100;
    b = '0;
    b[2] = row(2048, 2048, 0, 0);
    vecs[5].bout = b;
    vecs[5].score = 20'd2048;

    bus.direction = 4'd0;
    bus.board_in  = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_brd("rst_board", bus.board_out, '0);
    chk_scr("rst_score", bus.score_update, 20'd0);
    chk_bit("rst_done", bus.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 6; i++) do_move(i);

    // held direction: exactly one move
    @(negedge clk);
    bus.board_in  = vecs[2].bin;
    bus.direction = 4'b1000;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL hold_pulses got %0d want 1", pulses);
    end
    chk_brd("hold_board", bus.board_out, vecs[2].bout);
    bus.direction = 4'd0;
    repeat (2) @(negedge clk);

    // non-one-hot direction is ignored
    last_out = vecs[2].bout;
    bus.board_in  = vecs[0].bin;
    bus.direction = 4'b0011;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL bad_dir_pulses got %0d want 0", pulses);
    end
    chk_brd("bad_dir_board", bus.board_out, last_out);
    bus.direction = 4'd0;
    repeat (2) @(negedge clk);

    // reset during MERGE aborts the move
    bus.board_in  = vecs[1].bin;
    bus.direction = 4'b0100;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.direction = 4'd0;
    #1;
    chk_brd("mid_rst_board", bus.board_out, '0);
    chk_scr("mid_rst_score", bus.score_update, 20'd0);
    chk_bit("mid_rst_done", bus.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL post_rst_pulses got %0d want 0", pulses);
    end
    chk_brd("post_rst_board", bus.board_out, '0);

    // engine still works after the abort
    do_move(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
